// File: rtl/rob_pkg.sv
// Shared types and sizing for the reorder buffer / commit stage.
// Contents:
//   - sizing constants (depth, lane counts, widths)
//   - rob_idx_t / rob_cnt_t pointer and occupancy types
//   - rob_entry_t   : one ROB slot
//   - retire_lane_t : one retire lane, doubles as the ARF write-port payload
package rob_pkg;

  localparam int ROB_DEPTH      = 16;
  localparam int DISPATCH_PORTS = 2;
  localparam int WB_PORTS       = 4;
  localparam int RETIRE_PORTS   = 2;
  localparam int DATA_W         = 32;
  localparam int AREG_W         = 5;

  localparam int IDX_W  = $clog2(ROB_DEPTH);
  localparam int CNT_W  = IDX_W + 1;
  localparam int DCNT_W = $clog2(DISPATCH_PORTS + 1);
  localparam int RCNT_W = $clog2(RETIRE_PORTS + 1);

  typedef logic [IDX_W-1:0] rob_idx_t;
  typedef logic [CNT_W-1:0] rob_cnt_t;

  typedef struct packed {
    logic              valid;
    logic              done;
    logic              exc;
    logic              regwrite;
    logic [AREG_W-1:0] dst;
    logic [DATA_W-1:0] data;
  } rob_entry_t;

  typedef struct packed {
    logic              valid;
    logic              regwrite;
    logic [AREG_W-1:0] dst;
    logic [DATA_W-1:0] data;
  } retire_lane_t;

endpackage

// File: rtl/rob_commit_if.sv
// Pipeline-facing bus of the reorder buffer.
// Groups dispatch (valid/regwrite/dst -> ready/idx), writeback
// (valid/idx/data/exc), the retire lanes towards the ARF, flush and empty.
// master : the pipeline side that dispatches and writes back
// slave  : the reorder buffer itself
interface rob_commit_if;
  import rob_pkg::*;

  logic [DISPATCH_PORTS-1:0]             disp_valid;
  logic [DISPATCH_PORTS-1:0]             disp_regwrite;
  logic [DISPATCH_PORTS-1:0][AREG_W-1:0] disp_dst;
  logic                                  disp_ready;
  logic [DISPATCH_PORTS-1:0][IDX_W-1:0]  disp_idx;

  logic [WB_PORTS-1:0]                   wb_valid;
  logic [WB_PORTS-1:0][IDX_W-1:0]        wb_idx;
  logic [WB_PORTS-1:0][DATA_W-1:0]       wb_data;
  logic [WB_PORTS-1:0]                   wb_exc;

  logic [RETIRE_PORTS-1:0]               retire_valid;
  logic [RETIRE_PORTS-1:0]               retire_regwrite;
  logic [RETIRE_PORTS-1:0][AREG_W-1:0]   retire_dst;
  logic [RETIRE_PORTS-1:0][DATA_W-1:0]   retire_data;

  logic                                  flush;
  logic                                  empty;

  modport master (
    output disp_valid, disp_regwrite, disp_dst,
    input  disp_ready, disp_idx,
    output wb_valid, wb_idx, wb_data, wb_exc,
    input  retire_valid, retire_regwrite, retire_dst, retire_data,
    input  flush, empty
  );

  modport slave (
    input  disp_valid, disp_regwrite, disp_dst,
    output disp_ready, disp_idx,
    input  wb_valid, wb_idx, wb_data, wb_exc,
    output retire_valid, retire_regwrite, retire_dst, retire_data,
    output flush, empty
  );

endinterface

// File: rtl/rob_retire_sel.sv
// Combinational in-order retire chain.
// Ports:
//   win     in  : ROB entries starting at head (win[0] is the oldest)
//   lanes   out : retire lanes, regwrite already gated by valid and !exc
//   n_ret   out : number of lanes retiring this cycle
//   exc_ret out : the last retiring lane carries an exception
module rob_retire_sel
  import rob_pkg::*;
(
  input  rob_entry_t   [RETIRE_PORTS-1:0] win,
  output retire_lane_t [RETIRE_PORTS-1:0] lanes,
  output logic         [RCNT_W-1:0]       n_ret,
  output logic                            exc_ret
);

  logic go;

  // The chain stops at the first not-ready entry, and also right after an
  // exception entry so nothing younger than the faulting instruction retires.
  always_comb begin
    go      = 1'b1;
    n_ret   = '0;
    exc_ret = 1'b0;
    lanes   = '0;
    for (int k = 0; k < RETIRE_PORTS; k++) begin
      if (go && win[k].valid && win[k].done) begin
        lanes[k].valid    = 1'b1;
        lanes[k].regwrite = win[k].regwrite && !win[k].exc;
        lanes[k].dst      = win[k].dst;
        lanes[k].data     = win[k].data;
        n_ret             = n_ret + 1'b1;
        if (win[k].exc) begin
          exc_ret = 1'b1;
          go      = 1'b0;
        end
      end else begin
        go = 1'b0;
      end
    end
  end

endmodule

// File: rtl/rob_commit.sv
// In-order reorder buffer and commit stage.
// Ports:
//   clk    in : clock
//   resetn in : asynchronous active-low reset
//   bus       : rob_commit_if.slave (dispatch, writeback, retire, flush, empty)
// Dispatch is all-or-nothing against a free count taken from the pre-edge
// occupancy; writebacks mark entries done; up to RETIRE_PORTS oldest done
// entries retire per cycle. A retiring exception empties the buffer and
// raises flush for one cycle.
module rob_commit
  import rob_pkg::*;
(
  input  logic         clk,
  input  logic         resetn,
  rob_commit_if.slave  bus
);

  rob_entry_t q [ROB_DEPTH];
  rob_idx_t   head;
  rob_idx_t   tail;
  rob_cnt_t   count;
  logic       flush_q;

  logic [DCNT_W-1:0]                n_disp;
  logic                             accept;
  rob_entry_t   [RETIRE_PORTS-1:0]  win;
  retire_lane_t [RETIRE_PORTS-1:0]  lanes;
  logic         [RCNT_W-1:0]        n_ret;
  logic                             exc_ret;

  always_comb begin
    n_disp = '0;
    for (int i = 0; i < DISPATCH_PORTS; i++) begin
      if (bus.disp_valid[i]) n_disp = n_disp + 1'b1;
    end
  end

  // Slots freed by this cycle's retirement are deliberately not credited.
  assign bus.disp_ready = !flush_q &&
                          ((rob_cnt_t'(ROB_DEPTH) - count) >= rob_cnt_t'(n_disp));
  // A dispatch in the same cycle as an exception retire is discarded.
  assign accept = bus.disp_ready && (n_disp != '0) && !exc_ret;

  always_comb begin
    bus.disp_idx = '0;
    win          = '0;
    for (int i = 0; i < DISPATCH_PORTS; i++) begin
      bus.disp_idx[i] = tail + rob_idx_t'(i);
    end
    for (int k = 0; k < RETIRE_PORTS; k++) begin
      win[k] = q[head + rob_idx_t'(k)];
    end
  end

  rob_retire_sel u_retire_sel (
    .win     (win),
    .lanes   (lanes),
    .n_ret   (n_ret),
    .exc_ret (exc_ret)
  );

  always_comb begin
    bus.retire_valid    = '0;
    bus.retire_regwrite = '0;
    bus.retire_dst      = '0;
    bus.retire_data     = '0;
    for (int k = 0; k < RETIRE_PORTS; k++) begin
      bus.retire_valid[k]    = lanes[k].valid;
      bus.retire_regwrite[k] = lanes[k].regwrite;
      bus.retire_dst[k]      = lanes[k].dst;
      bus.retire_data[k]     = lanes[k].data;
    end
  end

  assign bus.flush = flush_q;
  assign bus.empty = (count == '0);

  // Writeback lanes are applied in ascending order so the highest-numbered
  // lane hitting an entry wins. Writebacks check the pre-edge valid bit, so
  // a write to a slot being allocated this cycle is dropped. Retired slots
  // drop valid so a wrapped head never sees stale entries.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      head    <= '0;
      tail    <= '0;
      count   <= '0;
      flush_q <= 1'b0;
      for (int j = 0; j < ROB_DEPTH; j++) q[j] <= '0;
    end else begin
      for (int w = 0; w < WB_PORTS; w++) begin
        if (bus.wb_valid[w] && q[bus.wb_idx[w]].valid) begin
          q[bus.wb_idx[w]].done <= 1'b1;
          q[bus.wb_idx[w]].data <= bus.wb_data[w];
          q[bus.wb_idx[w]].exc  <= bus.wb_exc[w];
        end
      end
      if (exc_ret) begin
        for (int j = 0; j < ROB_DEPTH; j++) q[j].valid <= 1'b0;
        head    <= '0;
        tail    <= '0;
        count   <= '0;
        flush_q <= 1'b1;
      end else begin
        flush_q <= 1'b0;
        for (int k = 0; k < RETIRE_PORTS; k++) begin
          if (lanes[k].valid) q[head + rob_idx_t'(k)].valid <= 1'b0;
        end
        if (accept) begin
          for (int i = 0; i < DISPATCH_PORTS; i++) begin
            if (bus.disp_valid[i]) begin
              q[tail + rob_idx_t'(i)] <= '{valid:    1'b1,
                                          done:     1'b0,
                                          exc:      1'b0,
                                          regwrite: bus.disp_regwrite[i],
                                          dst:      bus.disp_dst[i],
                                          data:     '0};
            end
          end
        end
        head  <= head + rob_idx_t'(n_ret);
        tail  <= tail + (accept ? rob_idx_t'(n_disp) : rob_idx_t'(0));
        count <= count + (accept ? rob_cnt_t'(n_disp) : rob_cnt_t'(0))
                       - rob_cnt_t'(n_ret);
      end
    end
  end

endmodule
